// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
package prog_loader_pkg;
    localparam int AW_DEF         = 10;
    localparam int DW_DEF         = 16;
    localparam int BYTES_PER_WORD = 2;
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, FLUSH, RUN, ERR
    } state_t;
endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
// A byte moves on every rising clk edge where rx_valid && rx_ready; the sender
// holds rx_data stable while rx_valid is high, and rx_ready never depends on rx_valid.
interface prog_loader_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          pm_we;
    logic [AW-1:0] pm_addr;
    logic [DW-1:0] pm_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, pm_we, pm_addr, pm_wdata
    );
    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, pm_we, pm_addr, pm_wdata
    );
endinterface

// File: rtl/prog_loader_asm.sv
// Byte-to-word assembler: latches the high byte and registers one program-memory write per word.
module prog_loader_asm
    import prog_loader_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hi_load,
    input  logic                         word_wr,
    input  logic [DW/BYTES_PER_WORD-1:0] rx_byte,
    input  logic [AW-1:0]                wr_addr,
    output logic                         pm_we,
    output logic [AW-1:0]                pm_addr,
    output logic [DW-1:0]                pm_wdata
);
    logic [DW-DW/BYTES_PER_WORD-1:0] hi_q, hi_d;
    logic                            pm_we_q, pm_we_d;
    logic [AW-1:0]                   pm_addr_q, pm_addr_d;
    logic [DW-1:0]                   pm_wdata_q, pm_wdata_d;

    always_comb begin
        hi_d       = hi_q;
        pm_we_d    = word_wr;
        pm_addr_d  = pm_addr_q;
        pm_wdata_d = pm_wdata_q;
        if (hi_load) hi_d = rx_byte;
        if (word_wr) begin
            pm_addr_d  = wr_addr;
            pm_wdata_d = {hi_q, rx_byte};
        end
    end

    // Reset clears pm_we_q asynchronously, so a write pending at reset never reaches memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q       <= '0;
            pm_we_q    <= 1'b0;
            pm_addr_q  <= '0;
            pm_wdata_q <= '0;
        end else begin
            hi_q       <= hi_d;
            pm_we_q    <= pm_we_d;
            pm_addr_q  <= pm_addr_d;
            pm_wdata_q <= pm_wdata_d;
        end
    end

    assign pm_we    = pm_we_q;
    assign pm_addr  = pm_addr_q;
    assign pm_wdata = pm_wdata_q;
endmodule

// File: rtl/prog_loader.sv
// Program loader: length-prefixed byte stream -> program memory, then releases the CPU.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.master bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          error,
    output state_t        dbg_state
);
    localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'(32'd1 << AW);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHK;
`else
    localparam state_t AFTER_DATA = FLUSH;
`endif

    state_t            state_q, state_d;
    logic [AW:0]       cnt_q, cnt_d, cnt_inc;
    logic [LEN_W-1:0]  len_q, len_d, len_next;
    logic              rx_ready, hs, hi_load, word_wr;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    assign hs       = bus.rx_valid && rx_ready;
    assign cnt_inc  = cnt_q + (AW+1)'(1);
    assign len_next = {len_q[LEN_W-1:8], bus.rx_data};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        hi_load = 1'b0;
        word_wr = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            LEN_HI: if (hs) begin
                len_d[LEN_W-1:8] = bus.rx_data;
                state_d          = LEN_LO;
            end
            LEN_LO: if (hs) begin
                len_d = len_next;
                if ({1'b0, len_next} > MAX_WORDS) state_d = ERR;
                else if (len_next == '0)          state_d = AFTER_DATA;
                else                              state_d = DATA_HI;
            end
            DATA_HI: if (hs) begin
                hi_load = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                xor_d   = xor_q ^ bus.rx_data;
`endif
                state_d = DATA_LO;
            end
            DATA_LO: if (hs) begin
                word_wr = 1'b1;
                cnt_d   = cnt_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
                xor_d   = xor_q ^ bus.rx_data;
`endif
                // Counter is one bit wider than the address so N == 2**AW ends cleanly.
                state_d = (LEN_W'(cnt_inc) == len_q) ? AFTER_DATA : DATA_HI;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: if (hs) begin
                state_d = (bus.rx_data == xor_q) ? FLUSH : ERR;
            end
`endif
            FLUSH:   state_d = RUN;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LEN_HI;
            cnt_q   <= '0;
            len_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    always_comb begin
        rx_ready  = 1'b0;
        cpu_reset = (state_q != RUN);
        done      = (state_q == RUN);
        error     = (state_q == ERR);
        case (state_q)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK: rx_ready = 1'b1;
            default:                               rx_ready = 1'b0;
        endcase
    end

    assign bus.rx_ready = rx_ready;
    assign dbg_state    = state_q;

    prog_loader_asm #(.AW(AW), .DW(DW)) u_asm (
        .clk      (clk),
        .reset    (reset),
        .hi_load  (hi_load),
        .word_wr  (word_wr),
        .rx_byte  (bus.rx_data),
        .wr_addr  (cnt_q[AW-1:0]),
        .pm_we    (bus.pm_we),
        .pm_addr  (bus.pm_addr),
        .pm_wdata (bus.pm_wdata)
    );
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: driver tasks feed byte streams, a monitor scores pm writes.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int AW = 10;
  localparam int DW = 16;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int LAST_WE_TO_RUN = 2;
`else
  localparam int LAST_WE_TO_RUN = 1;
`endif

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   cpu_reset, done, error;
  state_t dbg_state;

  prog_loader_if #(.AW(AW), .DW(DW)) bus();

  prog_loader #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [AW+DW-1:0] exp_q[$];
  logic [7:0]       stim_q[$];
  int checks = 0;
  int errors = 0;
  int last_we_cyc = -1;
  int last_hs_cyc = -1;
  int done_cyc = -1;
  bit gap_mode = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.pm_we === 1'b1) begin
      last_we_cyc = cyc;
      check("we_cpu_held", 32'(cpu_reset), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h:%h required=none", bus.pm_addr, bus.pm_wdata);
      end else begin
        check("pm_write", 32'({bus.pm_addr, bus.pm_wdata}), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    if (gap_mode) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      ok = bus.rx_ready;
      if (ok) last_hs_cyc = cyc;
      @(posedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout actual=no_ready required=accept byte %h", b);
    end
  endtask

  task automatic send_stream();
    foreach (stim_q[i]) send_byte(stim_q[i]);
    stim_q.delete();
  endtask

  task automatic idle();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic wait_done();
    done_cyc = -1;
    for (int t = 0; t < 20 && done_cyc < 0; t++) begin
      if (t > 0) @(negedge clk);
      if (done === 1'b1) done_cyc = cyc;
    end
    check("done", 32'(done), 32'd1);
    check("cpu_released", 32'(cpu_reset), 32'd0);
    check("no_error", 32'(error), 32'd0);
    check("state_run", 32'(dbg_state), 32'(RUN));
  endtask

  task automatic load_two_words();
    stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROG_LOADER_CHECKSUM_EN
    stim_q.push_back(8'h40);
`endif
    push_word(10'd0, 16'h1234);
    push_word(10'd1, 16'hABCD);
    send_stream();
    idle();
    wait_done();
    check("release_after_last_we", 32'(done_cyc - last_we_cyc), 32'(LAST_WE_TO_RUN));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(LEN_HI));
    check("rst_pm_we", 32'(bus.pm_we), 32'd0);
    check("rst_pm_addr", 32'(bus.pm_addr), 32'd0);
    check("rst_pm_wdata", 32'(bus.pm_wdata), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    reset = 1'b0;

    // two words, back-to-back bytes
    load_two_words();

    // empty image
    do_reset();
    stim_q = '{8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
    stim_q.push_back(8'h00);
`endif
    send_stream();
    idle();
    wait_done();
    check("empty_run_latency", 32'(done_cyc - last_hs_cyc), 32'd2);

    // oversize length 1025
    do_reset();
    stim_q = '{8'h04, 8'h01};
    send_stream();
    idle();
    @(negedge clk);
    check("ovr_error", 32'(error), 32'd1);
    check("ovr_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("ovr_cpu_reset", 32'(cpu_reset), 32'd1);
    check("ovr_done", 32'(done), 32'd0);
    check("ovr_state", 32'(dbg_state), 32'(ERR));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.rx_data  = 8'hAA;
      bus.rx_valid = 1'b1;
      check("err_ignores_bytes", 32'(bus.rx_ready), 32'd0);
    end
    idle();
    check("err_sticky", 32'(error), 32'd1);

    // same stream with rx_valid toggling
    do_reset();
    gap_mode = 1'b1;
    load_two_words();
    gap_mode = 1'b0;

    // reset right after the first word's low byte
    do_reset();
    stim_q = '{8'h00, 8'h02, 8'h12, 8'h34};
    send_stream();
    #1 reset = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_pm_we", 32'(bus.pm_we), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(LEN_HI));
    check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    reset = 1'b0;
    load_two_words();

    // largest image: 1024 words, data = address
    do_reset();
    stim_q = '{8'h04, 8'h00};
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] w;
      w = 16'(i);
      stim_q.push_back(w[15:8]);
      stim_q.push_back(w[7:0]);
      push_word(10'(i), w);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    stim_q.push_back(8'h00);
`endif
    send_stream();
    idle();
    wait_done();
    check("max_queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // checksum match and mismatch
    do_reset();
    stim_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    push_word(10'd0, 16'h1234);
    send_stream();
    idle();
    wait_done();
    do_reset();
    stim_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    push_word(10'd0, 16'h1234);
    send_stream();
    idle();
    @(negedge clk);
    check("chk_bad_error", 32'(error), 32'd1);
    check("chk_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("chk_bad_done", 32'(done), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
